// File: rtl/floor_request_ctrl.sv
// Elevator request/dispatch controller: call latching, sweep direction
// selection and door timing for the floor-movement FSM.
module floor_request_ctrl #(
  parameter int NUM_FLOORS  = 6,
  parameter int DOOR_CYCLES = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [NUM_FLOORS-1:0] callBtn,
  input  logic [NUM_FLOORS-1:0] currentFloor,
  output logic [NUM_FLOORS-1:0] reqFloors,
  output logic                  Up,
  output logic                  Down,
  output logic                  doorOpen,
  output logic                  hold,
  output logic                  floorErr
);

  localparam int CW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DOOR_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [NUM_FLOORS-1:0] F_ONE = NUM_FLOORS'(1);

  typedef enum logic [1:0] {
    IDLE,
    UP,
    DOWN,
    DOOR
  } state_t;

  state_t state, state_nx;

  logic [NUM_FLOORS-1:0] pending;
  logic [NUM_FLOORS-1:0] clr;
  logic [NUM_FLOORS-1:0] belowMask;
  logic [NUM_FLOORS-1:0] aboveMask;
  logic [CW-1:0]         doorCnt, doorCnt_nx;
  logic                  dirUp, dirUp_nx;
  logic                  above, below, here, hereCall;
  logic                  upFirst, doorBusy;

  // For a one-hot floor, floor-1 is exactly the mask of lower floors.
  always_comb begin
    belowMask = currentFloor - F_ONE;
    aboveMask = ~(belowMask | currentFloor);
    floorErr  = (currentFloor == '0) ||
                ((currentFloor & belowMask) != '0);
    above     = |(pending & aboveMask);
    below     = |(pending & belowMask);
    hereCall  = |(callBtn & currentFloor);
    here      = |(pending & currentFloor) | hereCall;
  end

  always_comb begin
    upFirst = 1'b1;
    unique case (1'b1)
      (state == DOWN): upFirst = 1'b0;
      (state == DOOR): upFirst = dirUp;
      default:         upFirst = 1'b1;
    endcase
  end

  assign doorBusy = hereCall || (doorCnt != '0);

  always_comb begin
    state_nx   = state;
    dirUp_nx   = dirUp;
    doorCnt_nx = doorCnt;
    clr        = '0;
    if (!floorErr) begin
      if (state != DOOR && here) begin
        state_nx   = DOOR;
        doorCnt_nx = CNT_LOAD;
        clr        = currentFloor;
      end else if (state == DOOR && doorBusy) begin
        clr        = currentFloor;
        doorCnt_nx = hereCall ? CNT_LOAD : doorCnt - CNT_ONE;
      end else begin
        // Preferred sweep first, reverse second, otherwise park.
        if (state == DOOR) clr = currentFloor;
        if (upFirst ? above : below) begin
          state_nx = upFirst ? UP : DOWN;
          dirUp_nx = upFirst;
        end else if (upFirst ? below : above) begin
          state_nx = upFirst ? DOWN : UP;
          dirUp_nx = !upFirst;
        end else begin
          state_nx = IDLE;
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      pending <= '0;
      doorCnt <= '0;
      dirUp   <= 1'b0;
    end else begin
      state   <= state_nx;
      pending <= (pending | callBtn) & ~clr;
      doorCnt <= doorCnt_nx;
      dirUp   <= dirUp_nx;
    end
  end

  assign reqFloors = pending;
  assign doorOpen  = (state == DOOR);
  assign hold      = doorOpen;
  assign Up        = (state == UP) || (state == DOOR && dirUp);
  assign Down      = (state == DOWN) || (state == DOOR && !dirUp);

endmodule

// File: tb/tb_floor_request_ctrl.sv
// Directed table-driven bench for floor_request_ctrl.
module tb_floor_request_ctrl;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [5:0] callBtn;
  logic [5:0] currentFloor;
  logic [5:0] reqFloors;
  logic       Up, Down, doorOpen, hold, floorErr;

  int n_cmp = 0;
  int n_bad = 0;

  floor_request_ctrl #(
    .NUM_FLOORS (6),
    .DOOR_CYCLES(4)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .callBtn     (callBtn),
    .currentFloor(currentFloor),
    .reqFloors   (reqFloors),
    .Up          (Up),
    .Down        (Down),
    .doorOpen    (doorOpen),
    .hold        (hold),
    .floorErr    (floorErr)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [5:0]  cb;
    logic [5:0]  cur;
    logic [10:0] exp;
  } vec_t;

  vec_t vt[$];

  localparam logic [5:0] F0 = 6'b000001;
  localparam logic [5:0] F1 = 6'b000010;
  localparam logic [5:0] F2 = 6'b000100;
  localparam logic [5:0] F3 = 6'b001000;
  localparam logic [5:0] F5 = 6'b100000;

  function automatic logic [10:0] pk(logic [5:0] r, logic u, logic d,
                                     logic o, logic e);
    return {r, u, d, o, o, e};
  endfunction

  function automatic logic [10:0] obs();
    return {reqFloors, Up, Down, doorOpen, hold, floorErr};
  endfunction

  task automatic add(logic [5:0] cb, logic [5:0] cur, logic [5:0] r,
                     logic u, logic d, logic o, logic e);
    vec_t v;
    v.cb  = cb;
    v.cur = cur;
    v.exp = pk(r, u, d, o, e);
    vt.push_back(v);
  endtask

  task automatic chk(string nm, logic [10:0] act, logic [10:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got req/U/D/door/hold/err=%b required %b",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    callBtn = '0;
    currentFloor = F0;
    step();
    step();
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    callBtn = '0;
    currentFloor = F0;

    // call floor 3 (2M) from floor 1, serve it
    add(F2, F0, F2,        0, 0, 0, 0);
    add(0,  F0, F2,        1, 0, 0, 0);
    add(0,  F1, F2,        1, 0, 0, 0);
    add(0,  F2, 0,         1, 0, 1, 0);
    add(0,  F2, 0,         1, 0, 1, 0);
    add(0,  F2, 0,         1, 0, 1, 0);
    add(0,  F2, 0,         1, 0, 1, 0);
    add(0,  F2, 0,         0, 0, 0, 0);
    // from 2M: calls at top and bottom, go up first then reverse
    add(F5 | F0, F2, F5 | F0, 0, 0, 0, 0);
    add(0,  F2, F5 | F0,   1, 0, 0, 0);
    add(0,  F3, F5 | F0,   1, 0, 0, 0);
    add(0,  F5, F0,        1, 0, 1, 0);
    add(0,  F5, F0,        1, 0, 1, 0);
    add(0,  F5, F0,        1, 0, 1, 0);
    add(0,  F5, F0,        1, 0, 1, 0);
    add(0,  F5, F0,        0, 1, 0, 0);
    add(0,  F3, F0,        0, 1, 0, 0);
    add(0,  F0, 0,         0, 1, 1, 0);
    add(0,  F0, 0,         0, 1, 1, 0);
    add(0,  F0, 0,         0, 1, 1, 0);
    add(0,  F0, 0,         0, 1, 1, 0);
    add(0,  F0, 0,         0, 0, 0, 0);
    // call at current floor in IDLE opens door, never latched
    add(F0, F0, 0,         0, 1, 1, 0);
    add(0,  F0, 0,         0, 1, 1, 0);

    do_reset();
    chk("reset_state", obs(), pk(0, 0, 0, 0, 0));

    for (int i = 0; i < vt.size(); i++) begin
      callBtn = vt[i].cb;
      currentFloor = vt[i].cur;
      step();
      chk($sformatf("vec%0d", i), obs(), vt[i].exp);
    end
    callBtn = '0;

    // door reload: call own floor when doorCnt==1
    do_reset();
    currentFloor = F1;
    callBtn = F1;
    step();
    chk("reload_open", obs(), pk(0, 0, 1, 1, 0));
    callBtn = '0;
    step();
    step();
    callBtn = F1;
    step();
    chk("reload_press", obs(), pk(0, 0, 1, 1, 0));
    callBtn = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("reload_hold%0d", i), obs(), pk(0, 0, 1, 1, 0));
    end
    step();
    chk("reload_close", obs(), pk(0, 0, 0, 0, 0));

    // floor error freezes FSM but still latches calls; reset mid-door
    do_reset();
    callBtn = F5;
    step();
    chk("err_pre", obs(), pk(F5, 0, 0, 0, 0));
    currentFloor = 6'b000110;
    callBtn = F0;
    #1;
    chk("err_multihot", obs(), pk(F5, 0, 0, 0, 1));
    step();
    chk("err_latch", obs(), pk(F5 | F0, 0, 0, 0, 1));
    currentFloor = '0;
    callBtn = '0;
    step();
    chk("err_zero", obs(), pk(F5 | F0, 0, 0, 0, 1));
    currentFloor = F0;
    step();
    chk("err_recover", obs(), pk(F5, 0, 1, 1, 0));
    Reset = 1'b1;
    callBtn = F2;
    step();
    chk("reset_middoor", obs(), pk(0, 0, 0, 0, 0));
    Reset = 1'b0;
    callBtn = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
